// File: rtl/ping_pong_monitor_if.sv
// Observation and result bundle between a ping-pong counter probe and its sequence monitor.
interface ping_pong_monitor_if #(
  parameter int W  = 4,
  parameter int CW = 8
);
  logic          valid;
  logic [W-1:0]  sample;
  logic          dir_in;
  logic [W-1:0]  max;
  logic [W-1:0]  min;
  logic          resync;
  logic          locked;
  logic          err;
  logic          err_sticky;
  logic [W-1:0]  expected;
  logic [CW-1:0] bounce_cnt;
  logic [CW-1:0] flip_cnt;

  modport master (
    output valid, sample, dir_in, max, min, resync,
    input  locked, err, err_sticky, expected, bounce_cnt, flip_cnt
  );

  modport slave (
    input  valid, sample, dir_in, max, min, resync,
    output locked, err, err_sticky, expected, bounce_cnt, flip_cnt
  );
endinterface

// File: rtl/ping_pong_monitor.sv
// Sequence checker for a ping-pong counter: tracks (value, direction) and flags illegal steps.
// Define PPM_FLIP_COUNT_EN to keep a live mid-range flip counter; otherwise flip_cnt reads 0.
module ping_pong_monitor #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input logic                 clk,
  input logic                 rst,
  ping_pong_monitor_if.slave  mon
);
  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_reg, state_next;
  logic [W-1:0]  prev_val_reg, prev_val_next;
  logic          prev_dir_reg, prev_dir_next;
  logic          err_reg, err_next;
  logic          err_sticky_reg, err_sticky_next;
  logic [CW-1:0] bounce_reg, bounce_next;

  logic [W:0] p_ext, p_inc, p_dec, s_ext;
  logic       bounds_ok, p_in, s_in, mid, is_hold, match_inc, match_dec;
  logic       legal, is_bounce;
`ifdef PPM_FLIP_COUNT_EN
  logic          is_flip;
  logic [CW-1:0] flip_reg, flip_next;
`endif

  // One extra bit keeps p+1 at the top and p-1 at zero from aliasing onto legal values.
  assign p_ext     = {1'b0, prev_val_reg};
  assign s_ext     = {1'b0, mon.sample};
  assign p_inc     = p_ext + {{W{1'b0}}, 1'b1};
  assign p_dec     = p_ext - {{W{1'b0}}, 1'b1};
  assign bounds_ok = mon.max > mon.min;
  assign p_in      = (prev_val_reg >= mon.min) && (prev_val_reg <= mon.max);
  assign s_in      = (mon.sample >= mon.min) && (mon.sample <= mon.max);
  assign mid       = (prev_val_reg > mon.min) && (prev_val_reg < mon.max);
  assign is_hold   = (mon.sample == prev_val_reg) && (mon.dir_in == prev_dir_reg);
  assign match_inc = (s_ext == p_inc) && mon.dir_in;
  assign match_dec = (s_ext == p_dec) && !mon.dir_in;

  always_comb begin
    legal     = 1'b0;
    is_bounce = 1'b0;
`ifdef PPM_FLIP_COUNT_EN
    is_flip   = 1'b0;
`endif
    if (!bounds_ok || !p_in) begin
      legal = is_hold;
    end else if (is_hold) begin
      legal = 1'b1;
    end else if ((prev_val_reg == mon.max) && prev_dir_reg) begin
      legal     = match_dec;
      is_bounce = match_dec;
    end else if ((prev_val_reg == mon.min) && !prev_dir_reg) begin
      legal     = match_inc;
      is_bounce = match_inc;
    end else if (prev_dir_reg ? match_inc : match_dec) begin
      legal = 1'b1;
    end else if (mid) begin
      legal = prev_dir_reg ? match_dec : match_inc;
`ifdef PPM_FLIP_COUNT_EN
      is_flip = legal;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    prev_val_next   = prev_val_reg;
    prev_dir_next   = prev_dir_reg;
    err_next        = 1'b0;
    err_sticky_next = err_sticky_reg;
    bounce_next     = bounce_reg;
`ifdef PPM_FLIP_COUNT_EN
    flip_next       = flip_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (mon.valid && bounds_ok && s_in) begin
          prev_val_next = mon.sample;
          prev_dir_next = mon.dir_in;
          state_next    = TRACK;
        end
      end
      TRACK: begin
        if (mon.resync) begin
          state_next = IDLE;
        end else if (mon.valid) begin
          if (legal) begin
            prev_val_next = mon.sample;
            prev_dir_next = mon.dir_in;
            if (is_bounce && (bounce_reg != CNT_MAX)) bounce_next = bounce_reg + 1'b1;
`ifdef PPM_FLIP_COUNT_EN
            if (is_flip && (flip_reg != CNT_MAX)) flip_next = flip_reg + 1'b1;
`endif
          end else begin
            err_next        = 1'b1;
            err_sticky_next = 1'b1;
            state_next      = ERROR;
          end
        end
      end
      ERROR: begin
        if (mon.resync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      prev_val_reg   <= '0;
      prev_dir_reg   <= 1'b0;
      err_reg        <= 1'b0;
      err_sticky_reg <= 1'b0;
      bounce_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      prev_val_reg   <= prev_val_next;
      prev_dir_reg   <= prev_dir_next;
      err_reg        <= err_next;
      err_sticky_reg <= err_sticky_next;
      bounce_reg     <= bounce_next;
    end
  end

`ifdef PPM_FLIP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) flip_reg <= '0;
    else     flip_reg <= flip_next;
  end
  assign mon.flip_cnt = flip_reg;
`else
  assign mon.flip_cnt = '0;
`endif

  assign mon.locked     = (state_reg == TRACK);
  assign mon.err        = err_reg;
  assign mon.err_sticky = err_sticky_reg;
  assign mon.expected   = prev_val_reg;
  assign mon.bounce_cnt = bounce_reg;
endmodule

// File: doc/ping_pong_monitor.md
# ping_pong_monitor

Sequence checker on the consumer side of the parameterized ping-pong counter. It samples the counter's `out`/`direction` pair on a strobe and predicts every legal next state from the shared `max`/`min` bounds. It flags illegal transitions and counts boundary bounces and mid-range flips. It sits downstream of the counter in lab benches and on-board self-check paths.

## Interface
- `W`, 4, width of value, `max`, `min`
- `CW`, 8, width of the bounce and flip counters (saturating)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `valid`  in  1  sample strobe; one observed counter state per asserted cycle
- `sample`  in  W  observed counter value
- `dir_in`  in  1  observed direction; 1 = up, 0 = down
- `max`, `min`  in  W each  bounds shared with the counter; treated as static while locked
- `resync`  in  1  leave ERROR or TRACK and return to IDLE
- `locked`  out  1  high in TRACK
- `err`  out  1  one-cycle pulse on an illegal transition
- `err_sticky`  out  1  set by `err`; cleared only by `rst`
- `expected`  out  W  last accepted sample, which is the reference for the next check
- `bounce_cnt`  out  CW  boundary turnarounds seen
- `flip_cnt`  out  CW  mid-range flips seen

## Operation
- States:
  - IDLE: waiting for the first sample
  - TRACK: checking each sample against the previous accepted state
  - ERROR: frozen after an illegal transition
- IDLE, `valid`:
  - `min<=sample<=max` and `max>min`: store `(sample,dir_in)` in `prev`, go to TRACK.
  - Otherwise stay in IDLE. No error is raised.
- TRACK, `valid`: the sample is legal when it matches one of these cases, evaluated in order against `prev=(p,d)`.
  1. **Frozen.** `max<=min` or `p` outside `[min,max]`. Only `(p,d)` is legal.
  2. **Hold.** `(p,d)`. Always legal; models `enable` low.
  3. **Top bounce.** `p==max`, `d==1`. Only `(p-1,0)` is legal. Increments `bounce_cnt`.
  4. **Bottom bounce.** `p==min`, `d==0`. Only `(p+1,1)` is legal. Increments `bounce_cnt`.
  5. **Step.** `(p+1,1)` if `d==1`; `(p-1,0)` if `d==0`.
  6. **Flip.** Requires `min<p<max`. `(p-1,0)` if `d==1`; `(p+1,1)` if `d==0`. Increments `flip_cnt`.
- Legal sample: update `prev`.
- Illegal sample: pulse `err`, set `err_sticky`, go to ERROR. `prev` keeps its last legal value.
- ERROR: ignores `valid`. `resync` goes to IDLE.
- `resync` in TRACK also goes to IDLE. It has priority over a simultaneous `valid`, and that sample is discarded.
- Arithmetic:
  - `p±1` is computed in W+1 bits, so no wrap aliasing occurs: `(p=15)+1` never matches `0`.
  - Counters saturate at `2^CW-1`.
  - Bounce and flip counters are not cleared by `resync`.

## Timing
- Reset values:
  - state IDLE
  - `locked=0`, `err=0`, `err_sticky=0`
  - `expected=0`, `bounce_cnt=0`, `flip_cnt=0`
- All outputs are registered. The effect of a `valid` in cycle N is visible in cycle N+1: `locked`, `err`, `expected`, and the counters.
- `err` is high for exactly one cycle per illegal sample.
- Back-to-back `valid` every cycle is supported with no bubbles.
- `rst` mid-operation overrides everything on that edge. It clears all state and both counters.

## Configuration
- Macro `PPM_FLIP_COUNT_EN`.
- Defined: `flip_cnt` is a live saturating counter.
- Undefined:
  - The `flip_cnt` register is removed and the port is driven constant 0.
  - Flips remain legal transitions and are still checked.

## Test plan
- Lock and step, `min=2`, `max=5`, `dir_in=1`, samples 2,3,4,5:
  - `locked=1` from the cycle after the first sample
  - `err` never pulses
  - `expected=5`
- Top bounce, `min=2`, `max=5`, samples (5,1)→(4,0):
  - `bounce_cnt=1`, no `err`
  - then (5,1)→(6,1) at `max` → `err` pulse, state ERROR, `err_sticky=1`
- Flip, `min=0`, `max=9`, samples (4,1)→(3,0) → `flip_cnt=1`:
  - then (0,0)→(1,1) → `bounce_cnt=1`
  - with the macro undefined, `flip_cnt` stays 0
- Freeze and hold:
  - `max=3`, `min=3`, lock rejected, so the monitor stays in IDLE with `locked=0`
  - in TRACK, repeated (4,1) → no `err`, counters unchanged
- Resync priority:
  - in ERROR, `valid` is ignored
  - `resync` together with `valid(7,1)` → IDLE and the sample is discarded
  - next `valid(7,1)` with `min=0`, `max=9` → `locked=1`, `err_sticky` still 1
- Reset mid-run after 3 bounces → next cycle shows IDLE and all outputs 0.
- Saturation with `CW=2`: 5 bounces → `bounce_cnt=3`.
